// File: rtl/fx2_slave_fifo_responder_pkg.sv
// Shared definitions for the FX2 slave FIFO responder: endpoint address
// mapping, flag polarity and the IN packet state encoding.
package fx2_slave_fifo_responder_pkg;

   localparam logic FLAG_ON  = 1'b0;
   localparam logic FLAG_OFF = 1'b1;

   typedef enum logic {
      IN_FILL  = 1'b0,
      IN_DRAIN = 1'b1
   } in_state_t;

   // FX2 maps endpoints 2/4/6/8 onto FIFOADR 0..3.
   function automatic logic [1:0] ep_fifoadr(input int unsigned ep);
      return 2'((ep - 2) >> 1);
   endfunction

endpackage

// File: rtl/fx2_slave_fifo_responder_if.sv
// FX2 slave FIFO pin bundle; master = FPGA I/O engine, slave = responder.
interface fx2_slave_fifo_responder_if;
   logic [1:0]  FIFOADR;
   logic        SLOE;
   logic        SLRD;
   logic        SLWR;
   logic        PKTEND;
   logic [15:0] FIFO_DATA_I;
   logic [15:0] FIFO_DATA_O;
   logic        FIFO_DATA_OE;
   logic        FLAGA;
   logic        FLAGB;
   logic        FLAGC;

   modport master (
      output FIFOADR, SLOE, SLRD, SLWR, PKTEND, FIFO_DATA_I,
      input  FIFO_DATA_O, FIFO_DATA_OE, FLAGA, FLAGB, FLAGC
   );

   modport slave (
      input  FIFOADR, SLOE, SLRD, SLWR, PKTEND, FIFO_DATA_I,
      output FIFO_DATA_O, FIFO_DATA_OE, FLAGA, FLAGB, FLAGC
   );
endinterface

// File: rtl/fx2_slave_fifo_responder_sync_fifo_w16.sv
// 16-bit synchronous FIFO with first-word-fall-through head output.
module sync_fifo_w16 #(
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic [15:0] push_data,
   input  logic        pop,
   output logic [15:0] head,
   output logic        empty,
   output logic        full
);

   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [15:0]           mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
         rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
         count  <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fx2_slave_fifo_responder.sv
// FX2 slave FIFO responder: OUT endpoint FIFO toward the master, IN endpoint
// packet buffer toward the host, plus FLAGA/B/C and sticky protocol errors.
module fx2_slave_fifo_responder
   import fx2_slave_fifo_responder_pkg::*;
#(
   parameter int unsigned USB_ENDPOINT_IN  = 2,
   parameter int unsigned USB_ENDPOINT_OUT = 6,
   parameter int unsigned OUT_DEPTH_LOG2   = 9,
   parameter int unsigned IN_PKT_WORDS     = 256
) (
   input  logic                         IFCLK,
   input  logic                         RESET_N,
   fx2_slave_fifo_responder_if.slave    fx2,
   input  logic [15:0]                  host_out_data,
   input  logic                         host_out_valid,
   output logic                         host_out_ready,
   output logic [15:0]                  host_in_data,
   output logic                         host_in_valid,
   output logic                         host_in_last,
   output logic                         host_in_zlp,
   input  logic                         host_in_ready,
   output logic                         err_wr_overflow,
   output logic                         err_protocol
);

   localparam logic [1:0]  IN_CODE  = ep_fifoadr(USB_ENDPOINT_IN);
   localparam logic [1:0]  OUT_CODE = ep_fifoadr(USB_ENDPOINT_OUT);
   localparam int unsigned AW       = $clog2(IN_PKT_WORDS);
   localparam int unsigned CW       = AW + 1;
   localparam logic [CW-1:0] PKT_LEN = CW'(IN_PKT_WORDS);

   logic          sel_in;
   logic          sel_out;
   logic          out_push;
   logic          out_pop;
   logic [15:0]   out_head;
   logic          out_empty;
   logic          out_full;

   assign sel_in  = (fx2.FIFOADR == IN_CODE);
   assign sel_out = (fx2.FIFOADR == OUT_CODE);

   // ---------------- OUT path ----------------
   assign out_push       = host_out_valid & ~out_full;
   assign out_pop        = ~fx2.SLRD & sel_out & ~out_empty;
   assign host_out_ready = ~out_full;

   sync_fifo_w16 #(
      .DEPTH_LOG2 (OUT_DEPTH_LOG2)
   ) u_out_fifo (
      .clk       (IFCLK),
      .rst_n     (RESET_N),
      .push      (out_push),
      .push_data (host_out_data),
      .pop       (out_pop),
      .head      (out_head),
      .empty     (out_empty),
      .full      (out_full)
   );

   assign fx2.FIFO_DATA_O  = out_head;
   assign fx2.FIFO_DATA_OE = ~fx2.SLOE & sel_out;
   assign fx2.FLAGC        = out_empty ? FLAG_ON : FLAG_OFF;

   // ---------------- IN path ----------------
   in_state_t     in_state;
   logic [CW-1:0] in_count;
   logic [CW-1:0] in_next_count;
   logic [CW-1:0] rd_ptr;
   logic [15:0]   in_ram [IN_PKT_WORDS];
   logic          in_fill;
   logic          fill_open;
   logic          wr_in;
   logic          in_wr;
   logic          commit_req;
   logic          beat_zlp;
   logic          beat_last;

   assign in_fill       = (in_state == IN_FILL);
   assign fill_open     = in_fill & (in_count < PKT_LEN);
   assign wr_in         = ~fx2.SLWR & sel_in;
   assign in_wr         = wr_in & fill_open;
   assign commit_req    = ~fx2.PKTEND & sel_in & in_fill;
   assign in_next_count = in_count + CW'(in_wr);

   // In IN_DRAIN in_count holds the committed packet length.
   assign beat_zlp  = (in_count == '0);
   assign beat_last = beat_zlp | (rd_ptr == in_count - CW'(1));

   always_ff @(posedge IFCLK) begin
      if (!RESET_N) begin
         in_state <= IN_FILL;
         in_count <= '0;
         rd_ptr   <= '0;
      end else begin
         case (in_state)
            IN_FILL: begin
               in_count <= in_next_count;
               rd_ptr   <= '0;
               if (commit_req || in_next_count == PKT_LEN)
                  in_state <= IN_DRAIN;
            end
            IN_DRAIN: begin
               if (host_in_ready) begin
                  if (beat_last) begin
                     in_state <= IN_FILL;
                     in_count <= '0;
                     rd_ptr   <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + CW'(1);
                  end
               end
            end
            default: in_state <= IN_FILL;
         endcase
      end
   end

   always_ff @(posedge IFCLK) begin
      if (RESET_N && in_wr)
         in_ram[in_count[AW-1:0]] <= fx2.FIFO_DATA_I;
   end

   assign host_in_valid = ~in_fill;
   assign host_in_data  = in_ram[rd_ptr[AW-1:0]];
   assign host_in_last  = ~in_fill & beat_last;
   assign host_in_zlp   = ~in_fill & beat_zlp;

   assign fx2.FLAGA = (in_fill && in_count == '0) ? FLAG_ON : FLAG_OFF;
   assign fx2.FLAGB = fill_open ? FLAG_OFF : FLAG_ON;

   // ---------------- sticky errors ----------------
   always_ff @(posedge IFCLK) begin
      if (!RESET_N) begin
         err_wr_overflow <= 1'b0;
         err_protocol    <= 1'b0;
      end else begin
         err_wr_overflow <= err_wr_overflow | (wr_in & ~fill_open);
         err_protocol    <= err_protocol
                            | (~fx2.SLRD & ~fx2.SLWR)
                            | (~fx2.SLOE & ~fx2.SLWR);
      end
   end

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Directed bench for fx2_slave_fifo_responder: inputs change and outputs are
// sampled on the falling edge of IFCLK.
module tb_fx2_slave_fifo_responder;

   logic        IFCLK;
   logic        RESET_N;
   logic [15:0] host_out_data;
   logic        host_out_valid;
   logic        host_out_ready;
   logic [15:0] host_in_data;
   logic        host_in_valid;
   logic        host_in_last;
   logic        host_in_zlp;
   logic        host_in_ready;
   logic        err_wr_overflow;
   logic        err_protocol;

   int n_vec = 0;
   int n_bad = 0;

   fx2_slave_fifo_responder_if fx2();

   fx2_slave_fifo_responder #(
      .USB_ENDPOINT_IN  (2),
      .USB_ENDPOINT_OUT (6),
      .OUT_DEPTH_LOG2   (9),
      .IN_PKT_WORDS     (256)
   ) dut (
      .IFCLK           (IFCLK),
      .RESET_N         (RESET_N),
      .fx2             (fx2),
      .host_out_data   (host_out_data),
      .host_out_valid  (host_out_valid),
      .host_out_ready  (host_out_ready),
      .host_in_data    (host_in_data),
      .host_in_valid   (host_in_valid),
      .host_in_last    (host_in_last),
      .host_in_zlp     (host_in_zlp),
      .host_in_ready   (host_in_ready),
      .err_wr_overflow (err_wr_overflow),
      .err_protocol    (err_protocol)
   );

   initial begin
      IFCLK = 1'b0;
      forever #5 IFCLK = ~IFCLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      fx2.FIFOADR     = 2'd3;
      fx2.SLOE        = 1'b1;
      fx2.SLRD        = 1'b1;
      fx2.SLWR        = 1'b1;
      fx2.PKTEND      = 1'b1;
      fx2.FIFO_DATA_I = 16'h0000;
      host_out_valid  = 1'b0;
   endtask

   initial begin
      idle();
      host_out_data = 16'h0000;
      host_in_ready = 1'b0;
      RESET_N       = 1'b0;
      repeat (2) @(negedge IFCLK);

      chk("rst_flaga", 32'(fx2.FLAGA), 32'd0);
      chk("rst_flagb", 32'(fx2.FLAGB), 32'd1);
      chk("rst_flagc", 32'(fx2.FLAGC), 32'd0);
      chk("rst_oe", 32'(fx2.FIFO_DATA_OE), 32'd0);
      chk("rst_in_valid", 32'(host_in_valid), 32'd0);
      chk("rst_out_ready", 32'(host_out_ready), 32'd1);
      chk("rst_errs", 32'({err_wr_overflow, err_protocol}), 32'd0);
      RESET_N = 1'b1;
      @(negedge IFCLK);

      // write on an unmapped FIFOADR must be ignored
      fx2.FIFOADR = 2'd1;
      fx2.SLWR    = 1'b0;
      fx2.FIFO_DATA_I = 16'h5555;
      @(negedge IFCLK);
      idle();
      chk("bad_addr_flaga", 32'(fx2.FLAGA), 32'd0);
      chk("bad_addr_ovf", 32'(err_wr_overflow), 32'd0);

      // OUT: four words, master reads six times
      for (int i = 0; i < 4; i++) begin
         host_out_valid = 1'b1;
         host_out_data  = 16'(i + 1);
         @(negedge IFCLK);
      end
      host_out_valid = 1'b0;
      chk("out_flagc_full", 32'(fx2.FLAGC), 32'd1);
      fx2.FIFOADR = 2'd2;
      fx2.SLOE    = 1'b0;
      fx2.SLRD    = 1'b0;
      #1;
      chk("out_oe", 32'(fx2.FIFO_DATA_OE), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("out_data", 32'(fx2.FIFO_DATA_O), 32'(k + 1));
         @(negedge IFCLK);
      end
      chk("out_flagc_empty", 32'(fx2.FLAGC), 32'd0);
      repeat (2) @(negedge IFCLK);
      chk("out_overread_flagc", 32'(fx2.FLAGC), 32'd0);
      chk("out_overread_err", 32'(err_protocol), 32'd0);
      chk("out_overread_ready", 32'(host_out_ready), 32'd1);
      idle();
      #1;
      chk("out_oe_off", 32'(fx2.FIFO_DATA_OE), 32'd0);

      // OUT: fill to 512, push while full is rejected, then drain and verify order
      for (int i = 0; i < 512; i++) begin
         host_out_valid = 1'b1;
         host_out_data  = 16'h1000 + 16'(i);
         @(negedge IFCLK);
      end
      chk("out_full_ready", 32'(host_out_ready), 32'd0);
      chk("out_full_head", 32'(fx2.FIFO_DATA_O), 32'h1000);
      host_out_data = 16'hFFFF;
      fx2.FIFOADR   = 2'd2;
      fx2.SLRD      = 1'b0;
      @(negedge IFCLK);
      host_out_valid = 1'b0;
      chk("out_ready_after_pop", 32'(host_out_ready), 32'd1);
      for (int i = 1; i < 512; i++) begin
         chk("out_drain_data", 32'(fx2.FIFO_DATA_O), 32'h1000 + 32'(i));
         @(negedge IFCLK);
      end
      chk("out_drained_flagc", 32'(fx2.FLAGC), 32'd0);
      idle();

      // IN: full 256-word packet
      chk("in_flaga_idle", 32'(fx2.FLAGA), 32'd0);
      fx2.FIFOADR = 2'd0;
      fx2.SLWR    = 1'b0;
      for (int i = 0; i < 256; i++) begin
         fx2.FIFO_DATA_I = 16'h0100 + 16'(i);
         @(negedge IFCLK);
         if (i == 0)   chk("in_flaga_one", 32'(fx2.FLAGA), 32'd1);
         if (i == 254) chk("in_flagb_255", 32'(fx2.FLAGB), 32'd1);
      end
      idle();
      chk("in_full_flagb", 32'(fx2.FLAGB), 32'd0);
      chk("in_full_valid", 32'(host_in_valid), 32'd1);
      host_in_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         chk("in_full_data", 32'(host_in_data), 32'h0100 + 32'(i));
         chk("in_full_last", 32'(host_in_last), 32'(i == 255));
         @(negedge IFCLK);
      end
      host_in_ready = 1'b0;
      chk("in_full_done_valid", 32'(host_in_valid), 32'd0);
      chk("in_full_done_flaga", 32'(fx2.FLAGA), 32'd0);
      chk("in_full_done_flagb", 32'(fx2.FLAGB), 32'd1);

      // IN: 5-word partial packet committed with PKTEND on the 5th write
      fx2.FIFOADR = 2'd0;
      fx2.SLWR    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fx2.FIFO_DATA_I = 16'hA000 + 16'(i);
         if (i == 4) fx2.PKTEND = 1'b0;
         @(negedge IFCLK);
      end
      idle();
      chk("pkt5_valid", 32'(host_in_valid), 32'd1);
      chk("pkt5_flagb", 32'(fx2.FLAGB), 32'd0);
      chk("pkt5_zlp", 32'(host_in_zlp), 32'd0);
      host_in_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("pkt5_data", 32'(host_in_data), 32'hA000 + 32'(i));
         chk("pkt5_last", 32'(host_in_last), 32'(i == 4));
         @(negedge IFCLK);
      end
      host_in_ready = 1'b0;
      chk("pkt5_done", 32'(host_in_valid), 32'd0);

      // IN: zero-length packet
      fx2.FIFOADR = 2'd0;
      fx2.PKTEND  = 1'b0;
      @(negedge IFCLK);
      idle();
      chk("zlp_valid", 32'(host_in_valid), 32'd1);
      chk("zlp_last", 32'(host_in_last), 32'd1);
      chk("zlp_flag", 32'(host_in_zlp), 32'd1);
      chk("zlp_flaga", 32'(fx2.FLAGA), 32'd1);
      host_in_ready = 1'b1;
      @(negedge IFCLK);
      host_in_ready = 1'b0;
      chk("zlp_done_valid", 32'(host_in_valid), 32'd0);
      chk("zlp_done_flaga", 32'(fx2.FLAGA), 32'd0);

      // IN: writes while draining are dropped and flagged
      fx2.FIFOADR = 2'd0;
      fx2.SLWR    = 1'b0;
      fx2.FIFO_DATA_I = 16'hB000;
      @(negedge IFCLK);
      fx2.FIFO_DATA_I = 16'hB001;
      fx2.PKTEND  = 1'b0;
      @(negedge IFCLK);
      fx2.PKTEND  = 1'b1;
      fx2.FIFO_DATA_I = 16'hDEAD;
      chk("ovf_before", 32'(err_wr_overflow), 32'd0);
      repeat (3) @(negedge IFCLK);
      idle();
      chk("ovf_set", 32'(err_wr_overflow), 32'd1);
      host_in_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("ovf_data", 32'(host_in_data), 32'hB000 + 32'(i));
         chk("ovf_last", 32'(host_in_last), 32'(i == 1));
         @(negedge IFCLK);
      end
      host_in_ready = 1'b0;
      chk("ovf_done_valid", 32'(host_in_valid), 32'd0);
      chk("ovf_sticky", 32'(err_wr_overflow), 32'd1);
      chk("ovf_no_proto", 32'(err_protocol), 32'd0);

      // protocol violation: SLRD and SLWR low together
      fx2.SLRD = 1'b0;
      fx2.SLWR = 1'b0;
      @(negedge IFCLK);
      idle();
      chk("proto_set", 32'(err_protocol), 32'd1);

      // reset in the middle of a drain
      fx2.FIFOADR = 2'd0;
      fx2.SLWR    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fx2.FIFO_DATA_I = 16'hC000 + 16'(i);
         if (i == 2) fx2.PKTEND = 1'b0;
         @(negedge IFCLK);
      end
      idle();
      chk("mid_valid", 32'(host_in_valid), 32'd1);
      RESET_N = 1'b0;
      @(negedge IFCLK);
      chk("mid_rst_valid", 32'(host_in_valid), 32'd0);
      chk("mid_rst_flaga", 32'(fx2.FLAGA), 32'd0);
      chk("mid_rst_flagb", 32'(fx2.FLAGB), 32'd1);
      chk("mid_rst_errs", 32'({err_wr_overflow, err_protocol}), 32'd0);
      RESET_N = 1'b1;
      @(negedge IFCLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
